inv_mix_columns_iter: RTL and testbench
=======================================

Name: inv_mix_columns_iter

Overview:
- Column-serial, handshaked inverse MixColumns unit for the AES decryption round datapath.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt pipeline.
- Computes the GF(2^8) product with matrix rows (0e 0b 0d 09), (09 0e 0b 0d), (0d 09 0e 0b), (0b 0d 09 0e). Field polynomial is x^8+x^4+x^3+x+1 (0x11B).
- Processes COLS_PER_CYCLE columns per clock, trading area for latency.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per compute cycle. Legal values 1, 2, 4; any other value is an elaboration error.
- COMPUTE_CYCLES, derived as 4/COLS_PER_CYCLE: not user-overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  unit can accept a block.
- in_state  in  128  input state. Byte k = bits [127-8k -: 8]. Column c = bytes 4c..4c+3; row r = byte 4c+r (FIPS-197 ordering).
- out_valid  out  1  out_state is valid.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  result, same byte layout as in_state.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - FSM goes to IDLE; column counter = 0.
  - in_ready=1, out_valid=0, out_state=0, working register=0.
  - Reset mid-operation discards the block in flight with no output.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch in_state into the working register, clear the counter, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, columns counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 of the working register are replaced in place with their inverse-mixed value. Then counter increments.
  - When counter = COMPUTE_CYCLES-1 the final group is written, out_state is loaded with the complete result, and the FSM goes to HOLD.
- HOLD:
  - out_valid=1; out_state stable; in_ready=0.
  - On out_ready: out_valid falls and the FSM goes to IDLE.
  - in_valid during HOLD is ignored.
- Latency: input accepted at edge T gives out_valid=1 after edge T+COMPUTE_CYCLES. COLS_PER_CYCLE=1 → 4 cycles; 2 → 2 cycles; 4 → 1 cycle.
- Throughput: one block per COMPUTE_CYCLES+2 cycles minimum with out_ready tied high.
- Arithmetic:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00).
  - x9 = x8^a; x11 = x8^x2^a; x13 = x8^x4^a; x14 = x8^x4^x2. Here x2=xtime(a), x4=xtime(x2), x8=xtime(x4).
  - All products are 8 bits; column sums are XOR.
- Per-cycle combinational logic covers only COLS_PER_CYCLE column cores; cores are indexed by the counter via a mux.
- The counter width is ceil(log2(COMPUTE_CYCLES)), minimum 1. It wraps only through the HOLD→IDLE path and is never observed at 4/4.
- No combinational path from in_valid or out_ready to in_ready or out_valid. Both are decoded from registered FSM state only.

Optional Feature:
- Macro: MIXCOL_BIDIR_EN.
- Defined:
  - Adds port dir_inv (in, 1), sampled and stored with in_state at the accept edge.
  - dir_inv=1 selects the inverse matrix above.
  - dir_inv=0 selects the forward matrix with rows (02 03 01 01), (01 02 03 01), (01 01 02 03), (03 01 01 02), on the same datapath.
  - Latency and handshake are unchanged.
- Undefined: no dir_inv port; always inverse.

Test Plan:
- Known column: one block with column 0 = 8e 4d a1 bc, other columns 00. Required out_state column 0 = db 13 53 45, others 00, out_valid exactly 4 cycles after accept (COLS_PER_CYCLE=1).
- Full block: columns 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6, 4d 7e bd f8 → f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6, 2d 26 31 4c. Repeat for COLS_PER_CYCLE=2 and 4, requiring latency 2 and 1.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a second block present. Required: out_state stable, in_ready=0, second block not accepted. Raising out_ready completes the transfer; the second block is accepted next IDLE cycle and its result is correct.
- Reset mid-CALC: pulse reset_n low asynchronously (mid-cycle) at the 2nd compute cycle. Required: out_valid=0, in_ready=1, out_state=0 immediately; no spurious output after release; the next block computes correctly.
- Round trip (MIXCOL_BIDIR_EN): 200 random blocks, forward then inverse. Required: output equals original; dir_inv=0 on db 13 53 45 gives 8e 4d a1 bc.
- Back-to-back with out_ready=1: 8 consecutive blocks. Required: in_ready re-asserts exactly one cycle after each out_valid handshake, and all 8 results match the reference model.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// Column-serial AES (Inv)MixColumns unit with valid/ready handshake.
// Optional MIXCOL_BIDIR_EN adds dir_inv to select forward/inverse matrix.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef MIXCOL_BIDIR_EN
  input  logic         dir_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int COMPUTE_CYCLES = 4 / COLS_PER_CYCLE;
  localparam int CW =
    (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [127:0]    work_nxt;
  logic            last;
  logic            mode;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // inv=1: rows (0e 0b 0d 09) rotated; inv=0: rows (02 03 01 01)
  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0] a   [4];
    logic [7:0] m2  [4];
    logic [7:0] m3  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] b   [4];
    logic [7:0] x4;
    logic [7:0] x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      m2[i]  = xtime(a[i]);
      x4     = xtime(m2[i]);
      x8     = xtime(x4);
      m3[i]  = m2[i] ^ a[i];
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ m2[i] ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ m2[i];
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        b[r] = m14[r] ^ m11[(r+1)%4]
             ^ m13[(r+2)%4] ^ m9[(r+3)%4];
      else
        b[r] = m2[r] ^ m3[(r+1)%4]
             ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  logic [31:0] cols     [4];
  logic [1:0]  idx      [COLS_PER_CYCLE];
  logic [31:0] core_in  [COLS_PER_CYCLE];
  logic [31:0] core_out [COLS_PER_CYCLE];

  assign last = (cnt == CW'(COMPUTE_CYCLES - 1));

  // split the working register into its four columns
  always_comb begin
    for (int c = 0; c < 4; c++)
      cols[c] = work[127-32*c -: 32];
  end

  genvar j;
  generate
    for (j = 0; j < COLS_PER_CYCLE; j++) begin : g_core
      assign idx[j] = 2'(int'(cnt) * COLS_PER_CYCLE + j);
      assign core_in[j] = cols[idx[j]];
      assign core_out[j] = mix_col(core_in[j], mode);
    end
  endgenerate

  // write the active column group back in place
  always_comb begin
    work_nxt = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      for (int c = 0; c < 4; c++)
        if (idx[k] == 2'(c))
          work_nxt[127-32*c -: 32] = core_out[k];
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // handshake outputs from registered state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

`ifdef MIXCOL_BIDIR_EN
  // direction captured alongside the block
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      mode <= 1'b1;
    else if (state == IDLE && in_valid) mode <= dir_inv;
  end
`else
  assign mode = 1'b1;
`endif

  // working register, column counter and result register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work      <= '0;
      cnt       <= '0;
      out_state <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            cnt  <= '0;
          end
        end
        CALC: begin
          work <= work_nxt;
          if (last) out_state <= work_nxt;
          else      cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (out_ready) cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed self-checking bench for inv_mix_columns_iter.
// Covers COLS_PER_CYCLE 1/2/4 and, with MIXCOL_BIDIR_EN, the forward path.
module tb_inv_mix_columns_iter;

  logic         clock;
  logic         reset_n;
  logic         iv  [3];
  logic         ir  [3];
  logic [127:0] is_ [3];
  logic         ov  [3];
  logic         ordy[3];
  logic [127:0] os  [3];
`ifdef MIXCOL_BIDIR_EN
  logic         dirv[3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KNOWN_IN  = {32'h8e4da1bc, 96'h0};
  localparam logic [127:0] KNOWN_EXP = {32'hdb135345, 96'h0};
  localparam logic [127:0] FULL_IN   =
    128'h9fdc589d_01010101_c6c6c6c6_4d7ebdf8;
  localparam logic [127:0] FULL_EXP  =
    128'hf20a225c_01010101_c6c6c6c6_2d26314c;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_state(is_[0]),
`ifdef MIXCOL_BIDIR_EN
    .dir_inv(dirv[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0])
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u2 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_state(is_[1]),
`ifdef MIXCOL_BIDIR_EN
    .dir_inv(dirv[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1])
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u4 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_state(is_[2]),
`ifdef MIXCOL_BIDIR_EN
    .dir_inv(dirv[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(
    input logic [127:0] s, input logic inv);
    logic [7:0]   co [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], co[(k-r+4)%4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // accept one block on instance u, wait for out_valid (left in HOLD)
  task automatic send(input int u, input logic [127:0] blk,
                      output logic [127:0] res, output int lat);
    int w;
    w = 0;
    while (!ir[u] && w < 20) begin tick(); w++; end
    iv[u]  = 1'b1;
    is_[u] = blk;
    tick();
    iv[u]  = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 20) begin tick(); lat++; end
    res = os[u];
  endtask

  task automatic release_out(input int u);
    ordy[u] = 1'b1;
    tick();
    ordy[u] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; is_[u] = '0;
`ifdef MIXCOL_BIDIR_EN
      dirv[u] = 1'b1;
`endif
    end
    #2;
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", ir[0]);
    end
    n_checks++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", ov[0]);
    end
    n_checks++;
    if (os[0] !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_out_state: got %h want 0", os[0]);
    end
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_known_column();
    logic [127:0] r;
    int lat;
    send(0, KNOWN_IN, r, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL known_latency: got %0d want 4", lat);
    end
    n_checks++;
    if (r !== KNOWN_EXP) begin
      n_fail++;
      $display("FAIL known_result: got %h want %h", r, KNOWN_EXP);
    end
    n_checks++;
    if (ir[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL known_hold_ready: got %b want 0", ir[0]);
    end
    release_out(0);
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL known_after_hs: valid %b ready %b want 0 1",
               ov[0], ir[0]);
    end
  endtask

  task automatic test_full_block();
    logic [127:0] r;
    int lat;
    send(0, FULL_IN, r, lat);
    n_checks++;
    if (lat !== 4 || r !== FULL_EXP) begin
      n_fail++;
      $display("FAIL full_cpc1: lat %0d res %h want 4 %h",
               lat, r, FULL_EXP);
    end
    release_out(0);
  endtask

  task automatic test_cols_per_cycle();
    logic [127:0] r;
    int lat;
    send(1, FULL_IN, r, lat);
    n_checks++;
    if (lat !== 2 || r !== FULL_EXP) begin
      n_fail++;
      $display("FAIL full_cpc2: lat %0d res %h want 2 %h",
               lat, r, FULL_EXP);
    end
    release_out(1);
    send(2, FULL_IN, r, lat);
    n_checks++;
    if (lat !== 1 || r !== FULL_EXP) begin
      n_fail++;
      $display("FAIL full_cpc4: lat %0d res %h want 1 %h",
               lat, r, FULL_EXP);
    end
    release_out(2);
    send(2, KNOWN_IN, r, lat);
    n_checks++;
    if (lat !== 1 || r !== KNOWN_EXP) begin
      n_fail++;
      $display("FAIL known_cpc4: lat %0d res %h want 1 %h",
               lat, r, KNOWN_EXP);
    end
    release_out(2);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    iv[0]  = 1'b1;
    is_[0] = KNOWN_IN;
    tick();
    is_[0] = FULL_IN;
    lat = 0;
    while (!ov[0] && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (lat !== 4 || os[0] !== KNOWN_EXP) begin
      n_fail++;
      $display("FAIL bp_first: lat %0d res %h want 4 %h",
               lat, os[0], KNOWN_EXP);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || os[0] !== KNOWN_EXP)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
    end
    release_out(0);
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid %b ready %b want 0 1",
               ov[0], ir[0]);
    end
    tick();
    iv[0] = 1'b0;
    n_checks++;
    if (ir[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: ready %b want 0", ir[0]);
    end
    lat = 0;
    while (!ov[0] && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (lat !== 4 || os[0] !== FULL_EXP) begin
      n_fail++;
      $display("FAIL bp_second: lat %0d res %h want 4 %h",
               lat, os[0], FULL_EXP);
    end
    release_out(0);
  endtask

  task automatic test_reset_mid_calc();
    logic [127:0] r;
    int lat;
    int bad;
    iv[0]  = 1'b1;
    is_[0] = KNOWN_IN;
    tick();
    iv[0]  = 1'b0;
    tick();
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || os[0] !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_mid: valid %b ready %b out %h want 0 1 0",
               ov[0], ir[0], os[0]);
    end
    #2 reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_spurious: %0d bad cycles want 0", bad);
    end
    send(0, FULL_IN, r, lat);
    n_checks++;
    if (lat !== 4 || r !== FULL_EXP) begin
      n_fail++;
      $display("FAIL rst_next_block: lat %0d res %h want 4 %h",
               lat, r, FULL_EXP);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [8];
    logic [127:0] exp_r;
    int lat;
    for (int i = 0; i < 8; i++)
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    is_[0]  = blk[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_r = mix_model(blk[i], 1'b1);
      if (i < 7) is_[0] = blk[i+1];
      else       iv[0]  = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 20) begin tick(); lat++; end
      n_checks++;
      if (lat !== 4 || os[0] !== exp_r) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: lat %0d res %h want 4 %h",
                 i, lat, os[0], exp_r);
      end
      tick();
      n_checks++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: ready %b valid %b want 1 0",
                 i, ir[0], ov[0]);
      end
    end
    ordy[0] = 1'b0;
  endtask

`ifdef MIXCOL_BIDIR_EN
  task automatic test_bidir();
    logic [127:0] orig;
    logic [127:0] fw;
    logic [127:0] back;
    int lat;
    int bad;
    dirv[0] = 1'b0;
    send(0, KNOWN_EXP, fw, lat);
    release_out(0);
    n_checks++;
    if (fw !== KNOWN_IN) begin
      n_fail++;
      $display("FAIL fwd_known: got %h want %h", fw, KNOWN_IN);
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      dirv[0] = 1'b0;
      send(0, orig, fw, lat);
      release_out(0);
      if (fw !== mix_model(orig, 1'b0)) bad++;
      dirv[0] = 1'b1;
      send(0, fw, back, lat);
      release_out(0);
      if (back !== orig) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL round_trip: %0d bad blocks want 0", bad);
    end
    dirv[0] = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_known_column();
    test_full_block();
    test_cols_per_cycle();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
`ifdef MIXCOL_BIDIR_EN
    test_bidir();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
